// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller for the multicycle control unit; optional IRQ_SYNC_EN adds 2-flop irq synchronizers.
// Latency: irq edge -> pending 1 cycle (3 with IRQ_SYNC_EN), pending -> irq_req 1 cycle; holds requests until eret.
module interrupt_controller #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_wr,
    input  logic [31:0]        cfg_wdata,
    input  logic [31:0]        pc_in,
    input  logic               irq_ack,
    input  logic               eret,
    output logic               irq_req,
    output logic               in_service,
    output logic [31:0]        epc,
    output logic [2:0]         cause,
    output logic [31:0]        vector,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] hist;
    logic [NUM_IRQ-1:0] enable;
    logic               gie;
    logic [NUM_IRQ-1:0] masked;
    logic [NUM_IRQ-1:0] eff_en;
    logic               eff_gie;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [2:0]         sel;
    logic               gie_nxt;
    logic               take;
    logic               ret;
    logic               unused_cfg;

    assign unused_cfg = ^cfg_wdata[30:NUM_IRQ];

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1, sync2;
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    assign masked     = pending & enable;
    assign take       = (state == REQ) && irq_ack;
    assign ret        = (state == SERVICE) && eret;
    assign irq_req    = (state == REQ);
    assign in_service = (state == SERVICE);
    assign vector     = VECTOR_BASE + {26'd0, cause, 3'b000};

    // A config write in REQ is judged on the values being written, so irq_req drops right after it.
    assign eff_en  = cfg_wr ? cfg_wdata[NUM_IRQ-1:0] : enable;
    assign eff_gie = cfg_wr ? cfg_wdata[31] : gie;

    always_comb begin
        sel = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) sel = 3'(i);
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = take && (sel == 3'(i));
        end
        // A fresh edge on the serviced line in the ack cycle survives the clear.
        pending_nxt = (pending & ~clr_mask) | (irq_s & ~hist);

        gie_nxt = eff_gie;
        if (take) gie_nxt = 1'b0;
        if (ret)  gie_nxt = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gie && (|masked)) state_nxt = REQ;
            end
            REQ: begin
                if (irq_ack)
                    state_nxt = SERVICE;
                else if (!(|(pending & eff_en)) || !eff_gie)
                    state_nxt = IDLE;
            end
            SERVICE: begin
                if (eret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            hist    <= '0;
            pending <= '0;
            enable  <= '0;
            gie     <= 1'b0;
            epc     <= '0;
            cause   <= '0;
        end else begin
            state   <= state_nxt;
            hist    <= irq_s;
            pending <= pending_nxt;
            gie     <= gie_nxt;
            if (cfg_wr) enable <= cfg_wdata[NUM_IRQ-1:0];
            if (take) begin
                epc   <= pc_in;
                cause <= sel;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (default build, irq used without synchronizer).
module tb_interrupt_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        cfg_wr;
    logic [31:0] cfg_wdata;
    logic [31:0] pc_in;
    logic        irq_ack;
    logic        eret;
    logic        irq_req;
    logic        in_service;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic [31:0] vector;
    logic [3:0]  pending;

    int checks = 0;
    int passed = 0;

    interrupt_controller #(.NUM_IRQ(4), .VECTOR_BASE(32'h0000_0100)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq        (irq),
        .cfg_wr     (cfg_wr),
        .cfg_wdata  (cfg_wdata),
        .pc_in      (pc_in),
        .irq_ack    (irq_ack),
        .eret       (eret),
        .irq_req    (irq_req),
        .in_service (in_service),
        .epc        (epc),
        .cause      (cause),
        .vector     (vector),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0; irq = 4'hF; cfg_wr = 1'b0; cfg_wdata = '0;
        pc_in = '0; irq_ack = 1'b0; eret = 1'b0;

        // 1: reset with all lines high
        tick(); tick();
        chk("rst_irq_req",    32'(irq_req),    32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_epc",        epc,             32'd0);
        chk("rst_cause",      32'(cause),      32'd0);
        chk("rst_pending",    32'(pending),    32'd0);
        chk("rst_vector",     vector,          32'h100);
        irq = 4'h0; reset = 1'b1;
        tick(); tick();
        chk("post_rst_pending", 32'(pending), 32'd0);
        // stray eret / ack in IDLE
        eret = 1'b1; irq_ack = 1'b1; pc_in = 32'hDEAD;
        tick();
        eret = 1'b0; irq_ack = 1'b0;
        chk("stray_in_service", 32'(in_service), 32'd0);
        chk("stray_epc",        epc,             32'd0);
        chk("stray_irq_req",    32'(irq_req),    32'd0);

        // 2: single line 2
        cfg_wr = 1'b1; cfg_wdata = 32'h8000_0004;
        tick();
        cfg_wr = 1'b0; irq = 4'b0100;
        tick();
        chk("t2_pending",     32'(pending), 32'h4);
        chk("t2_req_not_yet", 32'(irq_req), 32'd0);
        irq = 4'b0000;
        tick();
        chk("t2_irq_req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; pc_in = 32'h40;
        tick();
        irq_ack = 1'b0;
        chk("t2_epc",        epc,             32'h40);
        chk("t2_cause",      32'(cause),      32'd2);
        chk("t2_vector",     vector,          32'h110);
        chk("t2_in_service", 32'(in_service), 32'd1);
        chk("t2_pending_clr", 32'(pending),   32'd0);
        chk("t2_req_drop",   32'(irq_req),    32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t2_eret", 32'(in_service), 32'd0);

        // 3: lines 3 and 1 together, 1 wins
        cfg_wr = 1'b1; cfg_wdata = 32'h8000_000F;
        tick();
        cfg_wr = 1'b0; irq = 4'b1010;
        tick();
        irq = 4'b0000;
        chk("t3_pending", 32'(pending), 32'hA);
        tick();
        chk("t3_irq_req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; pc_in = 32'h80;
        tick();
        irq_ack = 1'b0;
        chk("t3_cause_first", 32'(cause),   32'd1);
        chk("t3_pending_left", 32'(pending), 32'h8);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t3_idle_after_eret", 32'(irq_req), 32'd0);
        tick();
        chk("t3_irq_req_again", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; pc_in = 32'h84;
        tick();
        irq_ack = 1'b0;
        chk("t3_cause_second", 32'(cause), 32'd3);
        chk("t3_vector",       vector,     32'h118);
        chk("t3_epc",          epc,        32'h84);

        // 4: edge during service waits for eret
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick(); tick();
        chk("t4_no_req_in_service", 32'(irq_req), 32'd0);
        chk("t4_pending_acc",       32'(pending), 32'h1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t4_req_eret_cycle", 32'(irq_req), 32'd0);
        tick();
        chk("t4_req_after_eret", 32'(irq_req), 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t4_cause", 32'(cause), 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // 5: disabling lines while requesting
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        chk("t5_irq_req", 32'(irq_req), 32'd1);
        cfg_wr = 1'b1; cfg_wdata = 32'h8000_0000;
        tick();
        cfg_wr = 1'b0;
        chk("t5_req_dropped", 32'(irq_req),    32'd0);
        chk("t5_not_service", 32'(in_service), 32'd0);
        chk("t5_pending_kept", 32'(pending),   32'h4);

        // 6: new edge on the serviced line in the ack cycle
        cfg_wr = 1'b1; cfg_wdata = 32'h8000_000F;
        tick();
        cfg_wr = 1'b0;
        tick();
        chk("t6_irq_req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; irq = 4'b0100; pc_in = 32'h200;
        tick();
        irq_ack = 1'b0; irq = 4'b0000;
        chk("t6_pending_set_wins", 32'(pending), 32'h4);
        chk("t6_cause",            32'(cause),   32'd2);
        chk("t6_epc",              epc,          32'h200);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        chk("t6_rerequest", 32'(irq_req), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
